// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types for the round-robin shared-register write arbiter.
package shared_reg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ACK, CLEAR} sra_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping at NREQ-1.
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    logic [PW:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            // explicit wrap keeps non-power-of-two NREQ in range
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!valid && req[idx[PW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for a shared clearable register.
// Define SHARED_REG_ARBITER_LOCK_EN to add the lock port (winner keeps priority).
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  sync_clr,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  clr_done,
    output logic                  busy,
    output logic [WIDTH-1:0]      q
`ifdef SHARED_REG_ARBITER_LOCK_EN
    ,
    input  logic [NREQ-1:0]       lock
`endif
);

    localparam int PW = ptr_width(NREQ);

    sra_state_t       state, state_nx;
    logic [PW-1:0]    ptr, ptr_nx;
    logic [PW-1:0]    win, win_nx;
    logic [PW-1:0]    pick;
    logic             pick_valid;
    logic [NREQ-1:0]  gnt_nx, ack_nx;
    logic             clr_done_nx;
    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] words [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign words[gi] = wdata[gi*WIDTH +: WIDTH];
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        win_nx      = win;
        gnt_nx      = gnt;
        ack_nx      = '0;
        clr_done_nx = 1'b0;
        q_nx        = q;
        case (state)
            IDLE: begin
                if (sync_clr) begin
                    state_nx = CLEAR;
                end else if (pick_valid) begin
                    win_nx       = pick;
                    gnt_nx       = '0;
                    gnt_nx[pick] = 1'b1;
                    state_nx     = LOAD;
                end
            end
            LOAD: begin
                if (req[win]) begin
                    q_nx        = words[win];
                    ack_nx[win] = 1'b1;
                    state_nx    = ACK;
                end else begin
                    // requester withdrew: abort without touching q or ptr
                    gnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            ACK: begin
                gnt_nx = '0;
                ptr_nx = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
`ifdef SHARED_REG_ARBITER_LOCK_EN
                if (lock[win]) begin
                    ptr_nx = win;
                end
`endif
                state_nx = IDLE;
            end
            CLEAR: begin
                q_nx        = '0;
                clr_done_nx = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            gnt      <= '0;
            ack      <= '0;
            clr_done <= 1'b0;
            busy     <= 1'b0;
            q        <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            win      <= win_nx;
            gnt      <= gnt_nx;
            ack      <= ack_nx;
            clr_done <= clr_done_nx;
            busy     <= (state_nx != IDLE);
            q        <= q_nx;
        end
    end

endmodule
